// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared constants for the memory responder
// Purpose : state encoding, word width and wait counter width used by
//           mem_responder and mem_resp_ram.
// Ports   : none (package).
// Option  : MEM_RESP_ERR_EN (used by mem_responder, not here).
package mem_resp_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/mem_resp_ram.sv
// rtl/mem_resp_ram.sv - word array with synchronous write, combinational read
// Purpose : backing store for mem_responder; contents are never reset.
// Ports   : clk      in  clock, rising edge
//           we       in  write enable
//           wrIndex  in  word index for the write
//           wrData   in  write data
//           rdIndex  in  word index for the read
//           rdData   out read data (combinational)
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wrIndex,
  input  logic [WORD_W-1:0]     wrData,
  input  logic [DEPTH_LOG2-1:0] rdIndex,
  output logic [WORD_W-1:0]     rdData
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wrIndex] <= wrData;
    end
  end

  assign rdData = mem[rdIndex];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with MemReady handshake
// Purpose : answers MemRead/MemWrite after WAIT_CYCLES wait states with a
//           one-cycle MemReady strobe; an IDLE cycle separates accesses.
// Ports   : clk, reset (async, active high)
//           MemRead, MemWrite in  request, held until MemReady
//           addr              in  byte address, word index addr[DEPTH_LOG2+1:2]
//           WriteData         in  write data
//           MemData           out read data, valid with MemReady on reads
//           MemReady          out one-cycle response strobe
//           MemErr            out error flag, valid with MemReady
// Option  : MEM_RESP_ERR_EN - flag misaligned and read+write requests as errors.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] MemData,
  output logic              MemReady,
  output logic              MemErr
);

  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  reqWrite;
  logic                  reqErr;
  logic [DEPTH_LOG2-1:0] reqIndex;
  logic [WORD_W-1:0]     reqData;

  logic                  reqActive;
  logic                  inErr;
  logic [DEPTH_LOG2-1:0] inIndex;
  logic [DEPTH_LOG2-1:0] rdIndex;
  logic [WORD_W-1:0]     rdData;
  logic                  ramWe;
  logic                  goResp;
  logic                  respErr;
  logic                  respWrite;
  logic                  unusedAddr;

  assign reqActive  = MemRead | MemWrite;
  assign inIndex    = addr[DEPTH_LOG2+1:2];
  assign unusedAddr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef MEM_RESP_ERR_EN
  assign inErr = (addr[1:0] != 2'b00) || (MemRead && MemWrite);
`else
  assign inErr = 1'b0;
`endif

  // With zero wait states the response is loaded straight from IDLE, so the
  // read port must see the incoming index rather than the latched one.
  assign rdIndex = (state == IDLE) ? inIndex : reqIndex;

  // The write lands at the edge leaving RESP; errored accesses never write.
  assign ramWe = (state == RESP) && reqWrite && !reqErr;

  always_comb begin
    goResp    = 1'b0;
    respErr   = reqErr;
    respWrite = reqWrite;
    if (state == IDLE) begin
      respErr   = inErr;
      respWrite = MemWrite;
      goResp    = reqActive && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      goResp = reqActive && (cnt == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      reqWrite <= 1'b0;
      reqErr   <= 1'b0;
      reqIndex <= '0;
      reqData  <= '0;
      MemData  <= '0;
      MemReady <= 1'b0;
      MemErr   <= 1'b0;
    end else begin
      MemReady <= goResp;
      MemErr   <= goResp && respErr;
      if (goResp) begin
        if (respErr) begin
          MemData <= '0;
        end else if (!respWrite) begin
          MemData <= rdData;
        end
      end

      case (state)
        IDLE: begin
          if (reqActive) begin
            reqWrite <= MemWrite;
            reqErr   <= inErr;
            reqIndex <= inIndex;
            reqData  <= WriteData;
            cnt      <= WAIT_INIT;
            state    <= goResp ? RESP : WAIT;
          end
        end
        WAIT: begin
          // A full deassert abandons the access without a response.
          if (!reqActive) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  mem_resp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) uRam (
    .clk    (clk),
    .we     (ramWe),
    .wrIndex(reqIndex),
    .wrData (reqData),
    .rdIndex(rdIndex),
    .rdData (rdData)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
// Purpose : checks reset state, latency, abort, wrap, zero-wait throughput,
//           error handling (MEM_RESP_ERR_EN aware) and mid-access reset.
// Ports   : none.
module tb_mem_responder;

`ifdef MEM_RESP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        rd, wr, rd0, wr0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic [31:0] data, data0;
  logic        ready, err, ready0, err0;

  int total;
  int bad;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .MemRead(rd), .MemWrite(wr), .addr(addr),
    .WriteData(wdata), .MemData(data), .MemReady(ready), .MemErr(err)
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0), .addr(addr0),
    .WriteData(wdata0), .MemData(data0), .MemReady(ready0), .MemErr(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance: accepted at E0, MemReady seen
  // only between E2 and E3, request dropped while MemReady is high.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input string tag,
                        input logic [31:0] expData, input logic expErr,
                        input logic chkData);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = wd;
    @(negedge clk);
    check({tag, "_rdy_e0"}, 32'(ready), 32'd0);
    @(negedge clk);
    check({tag, "_rdy_e1"}, 32'(ready), 32'd0);
    @(negedge clk);
    check({tag, "_rdy_e2"}, 32'(ready), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(expErr));
    if (chkData) check({tag, "_data"}, data, expData);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_e3"}, 32'(ready), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rd = 0; wr = 0; addr = 0; wdata = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst0_ready", 32'(ready0), 32'd0);
    check("rst0_err", 32'(err0), 32'd0);
    check("rst0_data", data0, 32'd0);

    // write then read; write response keeps previous MemData (0 after reset)
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10", 32'h0, 1'b0, 1'b1);
    access(1'b1, 1'b0, 32'h10, 32'h0, "rd10", 32'hDEADBEEF, 1'b0, 1'b1);

    // abort after one WAIT cycle: never a MemReady
    @(negedge clk);
    rd = 1'b1; addr = 32'h20;
    @(negedge clk);
    rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_rdy%0d", i), 32'(ready), 32'd0);
    end
    access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, "wr20", 32'h0, 1'b0, 1'b0);
    access(1'b1, 1'b0, 32'h20, 32'h0, "rd20", 32'hCAFEF00D, 1'b0, 1'b1);

    // address wrap: 0x400 aliases word 0
    access(1'b0, 1'b1, 32'h400, 32'h5, "wr400", 32'h0, 1'b0, 1'b0);
    access(1'b1, 1'b0, 32'h0, 32'h0, "rd0", 32'h5, 1'b0, 1'b1);
    access(1'b1, 1'b0, 32'h10, 32'h0, "rd10b", 32'hDEADBEEF, 1'b0, 1'b1);

    // misaligned read
    access(1'b1, 1'b0, 32'h13, 32'h0, "rd13",
           ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN, 1'b1);

    // read and write together
    access(1'b1, 1'b1, 32'h20, 32'h11111111, "rdwr20", 32'h0, ERR_EN, ERR_EN);
    access(1'b1, 1'b0, 32'h20, 32'h0, "rd20b",
           ERR_EN ? 32'hCAFEF00D : 32'h11111111, 1'b0, 1'b1);

    // zero wait states: response right after acceptance, reads every 2 cycles
    @(negedge clk);
    wr0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hA5A5A5A5;
    @(negedge clk);
    check("w0_wr_rdy", 32'(ready0), 32'd1);
    wr0 = 1'b0;
    @(negedge clk);
    check("w0_wr_idle", 32'(ready0), 32'd0);
    rd0 = 1'b1; addr0 = 32'h8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("w0_rd_rdy%0d", i), 32'(ready0), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) check($sformatf("w0_rd_data%0d", i), data0, 32'hA5A5A5A5);
    end
    rd0 = 1'b0;
    @(negedge clk);
    check("w0_rd_done", 32'(ready0), 32'd0);

    // reset in the middle of a write: dropped, outputs cleared at once
    @(negedge clk);
    wr = 1'b1; addr = 32'h10; wdata = 32'h0BADF00D;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_data", data, 32'd0);
    wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    access(1'b1, 1'b0, 32'h10, 32'h0, "rd10c", 32'hDEADBEEF, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
